d_mem_sync: RTL and testbench

//  Parametrised synchronous data memory for the cpu datapath.
//  - One write port, one registered read port with a valid flag.
//  - After reset, a built-in init sequencer fills the array: the first INIT_LEN

---
 rtl/d_mem_sync.sv | 149 ++++++++++++++
 tb/tb_d_mem_sync.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_sync.sv
// d_mem_sync - synchronous data memory for the cpu datapath.
//
// One write port and one registered read port with a valid flag. After reset
// a built-in init sequencer walks every word once: the first INIT_LEN words get
// the Fibonacci sequence 0,1,1,2,3,5,... (wrapping modulo 2**DATA_W), all others
// get zero. Requests are accepted only once ready is high.
//
// Build option:
//   D_MEM_FWD_EN  defined    -> same-address read+write returns the new wr_data
//                 undefined  -> same-address read+write returns the old word
//
// Ports:
//   clk       in   1       clock, rising edge
//   rst       in   1       synchronous active-high reset
//   ready     out  1       init finished, requests accepted
//   wr_en     in   1       write strobe
//   wr_addr   in   ADDR_W  write address (>= DEPTH is dropped)
//   wr_data   in   DATA_W  write data
//   rd_en     in   1       read strobe
//   rd_addr   in   ADDR_W  read address (>= DEPTH reads 0)
//   rd_data   out  DATA_W  registered read data
//   rd_valid  out  1       one-cycle pulse, rd_data is new this cycle
module d_mem_sync #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int INIT_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  typedef enum logic {INIT, RUN} state_e;

  // Comparisons are done one bit wider so DEPTH == 2**ADDR_W still fits.
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   INITLEN_W = (ADDR_W+1)'(INIT_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   fa_q, fa_d;
  logic [DATA_W-1:0]   fb_q, fb_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                init_we;
  logic [DATA_W-1:0]   init_word;
  logic                wr_in_range;
  logic                rd_in_range;
  logic                wr_ok;
  logic                fwd_hit;

  // State register: FSM, init sequencer and read output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      idx_q      <= '0;
      fa_q       <= '0;
      fb_q       <= DATA_W'(1);
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fa_q       <= fa_d;
      fb_q       <= fb_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state logic: INIT walks idx across the whole array once while the
  // Fibonacci pair advances every step, then RUN is held until reset.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    case (state_q)
      INIT: begin
        fa_d = fb_q;
        fb_d = fa_q + fb_q;
        if (idx_q == LAST_IDX) begin
          state_d = RUN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Output logic: init write word, request qualification and read mux.
  always_comb begin
    ready       = (state_q == RUN);
    init_we     = (state_q == INIT);
    init_word   = ({1'b0, idx_q} < INITLEN_W) ? fa_q : '0;
    wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    wr_ok       = ready && wr_en && wr_in_range;
`ifdef D_MEM_FWD_EN
    fwd_hit     = wr_ok && (wr_addr == rd_addr);
`else
    fwd_hit     = 1'b0;
`endif
    rd_valid_d  = ready && rd_en;
    rd_data_d   = rd_data_q;
    if (rd_valid_d) begin
      if (!rd_in_range) begin
        rd_data_d = '0;
      end else if (fwd_hit) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem[rd_addr];
      end
    end
  end

  // Storage array: no reset, it is rewritten by the init sequencer instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we) begin
        mem[idx_q] <= init_word;
      end else if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_d_mem_sync.sv
// tb_d_mem_sync - scoreboard bench for d_mem_sync.
// Three instances share one stimulus stream: default parameters, INIT_LEN=16
// (Fibonacci wrap) and DEPTH=200 (out-of-range addresses). Expected read data
// is computed from a bench-side memory model when a read is driven, queued,
// and compared when the instance produces rd_valid.
module tb_d_mem_sync;

  localparam int NDUT = 3;
  localparam int DEPTH_K   [NDUT] = '{256, 256, 200};
  localparam int INITLEN_K [NDUT] = '{8, 16, 8};

  logic       clk;
  logic       rst;
  logic       wrEn;
  logic [7:0] wrAddr;
  logic [7:0] wrData;
  logic       rdEn;
  logic [7:0] rdAddr;

  logic       readyV   [NDUT];
  logic [7:0] rdDataV  [NDUT];
  logic       rdValidV [NDUT];

  int assertCount;
  int failCount;

  logic [7:0] model [NDUT][256];
  logic [7:0] lastData [NDUT];
  logic [7:0] expQ0[$];
  logic [7:0] expQ1[$];
  logic [7:0] expQ2[$];

  int edgeCount;
  bit resetSeen;

  d_mem_sync dutDef (
    .clk(clk), .rst(rst), .ready(readyV[0]),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_en(rdEn), .rd_addr(rdAddr),
    .rd_data(rdDataV[0]), .rd_valid(rdValidV[0])
  );

  d_mem_sync #(.INIT_LEN(16)) dutFib16 (
    .clk(clk), .rst(rst), .ready(readyV[1]),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_en(rdEn), .rd_addr(rdAddr),
    .rd_data(rdDataV[1]), .rd_valid(rdValidV[1])
  );

  d_mem_sync #(.DEPTH(200)) dutD200 (
    .clk(clk), .rst(rst), .ready(readyV[2]),
    .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .rd_en(rdEn), .rd_addr(rdAddr),
    .rd_data(rdDataV[2]), .rd_valid(rdValidV[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void pushExp(input int k, input logic [7:0] v);
    case (k)
      0:       expQ0.push_back(v);
      1:       expQ1.push_back(v);
      default: expQ2.push_back(v);
    endcase
  endfunction

  function automatic logic [7:0] popExp(input int k);
    case (k)
      0:       return expQ0.pop_front();
      1:       return expQ1.pop_front();
      default: return expQ2.pop_front();
    endcase
  endfunction

  function automatic int qSize(input int k);
    case (k)
      0:       return expQ0.size();
      1:       return expQ1.size();
      default: return expQ2.size();
    endcase
  endfunction

  // Rebuild the reference contents: Fibonacci prefix, zeros elsewhere.
  task automatic initModel();
    logic [7:0] fa, fb, nxt;
    for (int k = 0; k < NDUT; k++) begin
      fa = 8'd0;
      fb = 8'd1;
      for (int i = 0; i < 256; i++) begin
        model[k][i] = (i < INITLEN_K[k]) ? fa : 8'd0;
        nxt = fa + fb;
        fa  = fb;
        fb  = nxt;
      end
    end
  endtask

  // Value a read should return, given the write happening in the same cycle.
  function automatic logic [7:0] expRead(input int k, input logic [7:0] addr,
                                         input logic wen, input logic [7:0] waddr,
                                         input logic [7:0] wdata);
    if (int'(addr) >= DEPTH_K[k]) return 8'd0;
`ifdef D_MEM_FWD_EN
    if (wen && waddr == addr) return wdata;
`else
    if (wen && waddr == addr && wdata == 8'hxx) return wdata;
`endif
    return model[k][addr];
  endfunction

  // One cycle of RUN-mode stimulus; queues read expectations, updates model.
  task automatic applyStimulus(input logic rEn, input logic [7:0] rAddr,
                               input logic wEn, input logic [7:0] wAddr,
                               input logic [7:0] wData);
    @(negedge clk);
    rdEn   = rEn;
    rdAddr = rAddr;
    wrEn   = wEn;
    wrAddr = wAddr;
    wrData = wData;
    for (int k = 0; k < NDUT; k++) begin
      if (rEn) pushExp(k, expRead(k, rAddr, wEn, wAddr, wData));
      if (wEn && int'(wAddr) < DEPTH_K[k]) model[k][wAddr] = wData;
    end
  endtask

  // Wait for all instances to finish init; optionally poke requests at them
  // meanwhile, which must be ignored.
  task automatic waitReady(input bit driveInit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (readyV[0] === 1'b1 && readyV[1] === 1'b1 && readyV[2] === 1'b1) begin
        done = 1'b1;
      end else begin
        rdEn   = driveInit && (i < 100);
        wrEn   = driveInit && (i < 100);
        rdAddr = 8'd5;
        wrAddr = 8'd5;
        wrData = 8'hEE;
      end
    end
    rdEn = 1'b0;
    wrEn = 1'b0;
    checkOutput("readyTimeout", {31'b0, done}, 32'd1);
  endtask

  // Monitor: sample just after each rising edge and compare against the
  // scoreboard and the ready-timing expectation.
  always @(posedge clk) begin
    logic rstAtEdge;
    logic expValid;
    logic [7:0] v;
    rstAtEdge = rst;
    #1;
    if (rstAtEdge) begin
      resetSeen = 1'b1;
      edgeCount = 0;
      expQ0.delete();
      expQ1.delete();
      expQ2.delete();
      for (int k = 0; k < NDUT; k++) begin
        checkOutput($sformatf("rstValid%0d", k), {31'b0, rdValidV[k]}, 32'd0);
        checkOutput($sformatf("rstReady%0d", k), {31'b0, readyV[k]}, 32'd0);
        checkOutput($sformatf("rstData%0d", k), {24'b0, rdDataV[k]}, 32'd0);
        lastData[k] = 8'd0;
      end
    end else if (resetSeen) begin
      edgeCount++;
      for (int k = 0; k < NDUT; k++) begin
        checkOutput($sformatf("ready%0d", k), {31'b0, readyV[k]},
                    {31'b0, (edgeCount >= DEPTH_K[k])});
        expValid = (qSize(k) > 0);
        checkOutput($sformatf("valid%0d", k), {31'b0, rdValidV[k]}, {31'b0, expValid});
        if (expValid) begin
          v = popExp(k);
          checkOutput($sformatf("rdData%0d", k), {24'b0, rdDataV[k]}, {24'b0, v});
          lastData[k] = v;
        end else begin
          checkOutput($sformatf("hold%0d", k), {24'b0, rdDataV[k]}, {24'b0, lastData[k]});
        end
      end
    end
  end

  initial begin
    logic [7:0] a, b;
    logic       re, we;
    assertCount = 0;
    failCount   = 0;
    edgeCount   = 0;
    resetSeen   = 1'b0;
    rst    = 1'b1;
    wrEn   = 1'b0;
    wrAddr = 8'd0;
    wrData = 8'd0;
    rdEn   = 1'b0;
    rdAddr = 8'd0;
    initModel();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waitReady(1'b1);

    // Fibonacci prefix and zero words, including the top address.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b1, 8'd255, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);

    // Write then read back; back-to-back reads.
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd20, 8'hA5);
    applyStimulus(1'b1, 8'd20, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
    for (int i = 3; i < 6; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'd0, 8'd0);

    // Wrap region of the longer Fibonacci prefix.
    for (int i = 13; i < 17; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'd0, 8'd0);

    // Same-address read and write, then plain read.
    applyStimulus(1'b1, 8'd6, 1'b1, 8'd6, 8'h3C);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b1, 8'd6, 1'b0, 8'd0, 8'd0);

    // Out-of-range for the 200-word instance; word 5 untouched by init pokes.
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd210, 8'hFF);
    applyStimulus(1'b1, 8'd210, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b1, 8'd199, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b1, 8'd5, 1'b0, 8'd0, 8'd0);

    // Simultaneous read and write to different addresses.
    applyStimulus(1'b1, 8'd20, 1'b1, 8'd30, 8'h11);
    applyStimulus(1'b1, 8'd30, 1'b0, 8'd0, 8'd0);

    // Random mix, with frequent same-address collisions.
    for (int i = 0; i < 80; i++) begin
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      b  = ($urandom_range(0, 2) == 0) ? a : 8'($urandom_range(0, 255));
      applyStimulus(re, a, we, b, 8'($urandom));
    end
    for (int i = 190; i < 210; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'd0, 8'd0);

    // Reset mid-operation: the read issued with reset is discarded and the
    // array is re-initialised.
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd2, 8'h77);
    applyStimulus(1'b1, 8'd2, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    rst    = 1'b1;
    rdEn   = 1'b1;
    rdAddr = 8'd2;
    wrEn   = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    rdEn = 1'b0;
    initModel();
    waitReady(1'b1);
    applyStimulus(1'b1, 8'd2, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b1, 8'd5, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b1, 8'd20, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
    @(posedge clk);
    #3;
    checkOutput("queueDrained", 32'(qSize(0) + qSize(1) + qSize(2)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
